// File: rtl/huffman_pkg.sv
// Shared entropy-coder types plus the component arbiter's grant and FIFO entry types.
package huffman_pkg;

    typedef struct packed {
        logic [4:0]  length;
        logic [15:0] code;
    } fixedLength_t;

    localparam int NUM_COMP = 3;

    typedef enum logic [1:0] {COMP_Y, COMP_CB, COMP_CR} comp_e;

    typedef struct packed {
        fixedLength_t word;
        logic         last;
    } arb_entry_t;

endpackage

// File: rtl/jpeg_comp_arbiter_fifo.sv
// Per-component synchronous FIFO of arb_entry_t with a pointer flush; head is read straight from storage.
module arb_fifo
    import huffman_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  arb_entry_t push_data,
    input  logic       pop,
    output arb_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    arb_entry_t  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jpeg_comp_arbiter.sv
// Interleaves Y/Cb/Cr coded word streams into MCU order, granting whole blocks at a time.
// Optional per-component input stall counters: define JPEG_ARB_STALL_CNT_EN.
module jpeg_comp_arbiter
    import huffman_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int Y_BLOCKS = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_start,
    input  logic [NUM_COMP-1:0]               in_valid,
    input  fixedLength_t [NUM_COMP-1:0]       in_word,
    input  logic [NUM_COMP-1:0]               in_last,
    output logic [NUM_COMP-1:0]               in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output fixedLength_t                      out_word,
    output logic [1:0]                        out_comp,
    output logic                              out_blk_last,
    output logic                              out_mcu_last,
`ifdef JPEG_ARB_STALL_CNT_EN
    output logic [NUM_COMP-1:0][15:0]         stall_cnt,
`endif
    output logic [15:0]                       mcu_count
);

    // state   | meaning
    // COMP_Y  | Y FIFO granted, yblk counts completed Y blocks in this MCU
    // COMP_CB | Cb FIFO granted for one block
    // COMP_CR | Cr FIFO granted for one block; its last word closes the MCU

    localparam int YBW = (Y_BLOCKS > 1) ? $clog2(Y_BLOCKS) : 1;

    comp_e                state;
    logic [YBW-1:0]       yblk;
    arb_entry_t           head [NUM_COMP];
    logic [NUM_COMP-1:0]  full;
    logic [NUM_COMP-1:0]  empty;
    logic [NUM_COMP-1:0]  push;
    logic [NUM_COMP-1:0]  pop;
    arb_entry_t           sel_head;
    logic                 sel_empty;
    logic                 blk_done;

    for (genvar i = 0; i < NUM_COMP; i++) begin : g_fifo
        assign in_ready[i] = !full[i];
        assign push[i]     = in_valid[i] && !full[i] && !frame_start;
        assign pop[i]      = out_valid && out_ready && !frame_start && (state == comp_e'(i));

        arb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (frame_start),
            .push      (push[i]),
            .push_data ({in_word[i], in_last[i]}),
            .pop       (pop[i]),
            .head      (head[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    always_comb begin
        sel_head  = head[0];
        sel_empty = empty[0];
        case (state)
            COMP_CB: begin
                sel_head  = head[1];
                sel_empty = empty[1];
            end
            COMP_CR: begin
                sel_head  = head[2];
                sel_empty = empty[2];
            end
            default: begin
                sel_head  = head[0];
                sel_empty = empty[0];
            end
        endcase
    end

    assign out_valid    = !sel_empty;
    assign out_word     = sel_head.word;
    assign out_blk_last = sel_head.last;
    assign out_comp     = state;
    assign out_mcu_last = sel_head.last && (state == COMP_CR);
    assign blk_done     = out_valid && out_ready && sel_head.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COMP_Y;
            yblk      <= '0;
            mcu_count <= '0;
        end else if (frame_start) begin
            state     <= COMP_Y;
            yblk      <= '0;
            mcu_count <= '0;
        end else if (blk_done) begin
            case (state)
                COMP_Y: begin
                    if (yblk == YBW'(Y_BLOCKS - 1)) begin
                        yblk  <= '0;
                        state <= COMP_CB;
                    end else begin
                        yblk <= yblk + 1'b1;
                    end
                end
                COMP_CB: state <= COMP_CR;
                COMP_CR: begin
                    state     <= COMP_Y;
                    mcu_count <= mcu_count + 16'd1;
                end
                default: state <= COMP_Y;
            endcase
        end
    end

`ifdef JPEG_ARB_STALL_CNT_EN
    for (genvar i = 0; i < NUM_COMP; i++) begin : g_stall
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stall_cnt[i] <= '0;
            end else if (frame_start) begin
                stall_cnt[i] <= '0;
            end else if (in_valid[i] && full[i] && (stall_cnt[i] != 16'hFFFF)) begin
                stall_cnt[i] <= stall_cnt[i] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/jpeg_comp_arbiter.md
# jpeg_comp_arbiter

Sequences the three per-component entropy-coded word streams (Y, Cb, Cr) from the JPEG coder into one interleaved output stream in JPEG MCU order. It sits between the coder's three `huffman_pkg::fixedLength_t` outputs and the bitstream packer/writer. Each component gets a small input FIFO. A fixed-order scheduler grants one component at a time and holds the grant for whole 8x8 blocks.

## Interface
- `DEPTH`, default 16: per-component FIFO depth in words; power of two, ≥2.
- `Y_BLOCKS`, default 1: Y blocks per MCU (1 = 4:4:4, 2 = 4:2:2, 4 = 4:2:0).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse; aborts the current frame and restarts the MCU order.
- `in_valid` in [3]: word valid, per component (index 0 = Y, 1 = Cb, 2 = Cr).
- `in_word` in `$bits(fixedLength_t)` x [3]: coded word.
- `in_last` in [3]: word is the last of its 8x8 block.
- `in_ready` out [3]: FIFO not full.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts.
- `out_word` out `$bits(fixedLength_t)`: granted word.
- `out_comp` out 2: component of `out_word` (0/1/2).
- `out_blk_last` out 1: last word of a block.
- `out_mcu_last` out 1: last word of the last Cr block of an MCU.
- `mcu_count` out 16: MCUs completed since the last `frame_start`; wraps.

## Operation
- Input transfer: when `in_valid[i] && in_ready[i]`, the word and its `in_last` are written into FIFO i. `in_ready[i] = !full[i]`.
- FSM states: `GNT_Y`, `GNT_CB`, `GNT_CR`.
  - Reset and `frame_start` both enter `GNT_Y` with `yblk = 0`.
  - `GNT_Y`: presents the head of FIFO 0. On the handshake of an `in_last` word: if `yblk == Y_BLOCKS-1`, clear `yblk` and go to `GNT_CB`; otherwise increment `yblk` and stay.
  - `GNT_CB`: on the last-word handshake, go to `GNT_CR`.
  - `GNT_CR`: on the last-word handshake, go to `GNT_Y` and increment `mcu_count`.
- Non-granted FIFOs only accumulate. The grant never moves mid-block, even if the granted FIFO is empty.
- Outputs:
  - `out_valid` = granted FIFO non-empty.
  - `out_word` / `out_blk_last` = FIFO head.
  - `out_comp` = state encoding.
  - `out_mcu_last = out_blk_last && state == GNT_CR`.
- Pop occurs on `out_valid && out_ready`.
- `out_word` and `out_blk_last` hold stable while `out_valid && !out_ready`.
- `frame_start` takes priority over all other events in the same cycle:
  - flushes all three FIFOs (pointers cleared);
  - drops any concurrent input write and output pop;
  - clears `mcu_count`.
- Simultaneous push and pop on one FIFO is allowed when full (pop frees the slot first) and when empty (fall-through is not permitted; see Timing).

## Timing
- Reset values:
  - `in_ready = 3'b111`
  - `out_valid = 0`, `out_word = 0`, `out_comp = 0`
  - `out_blk_last = 0`, `out_mcu_last = 0`
  - `mcu_count = 0`
  - state `GNT_Y`
- Latency: a word written at edge t is visible on `out_*` after edge t (the next cycle) if its component is granted.
- Grant switch costs zero cycles. After the last-word handshake at edge t, the next component's head is presented in cycle t+1.
- Full-rate throughput: one word per cycle while the granted FIFO is non-empty and `out_ready` is high.
- `out_*` are driven from FIFO registers and state only; there is no combinational path from `in_*` to `out_*`.

## Configuration
- `JPEG_ARB_STALL_CNT_EN` defined:
  - adds output `stall_cnt[3]` (16 bits each), incrementing per cycle that `in_valid[i] && !in_ready[i]`;
  - saturates at 16'hFFFF;
  - cleared by reset and `frame_start`.
- Undefined: the port and counters are absent.

## Structure
- `huffman_pkg` gains:
  - `NUM_COMP = 3`;
  - `typedef enum logic [1:0] {COMP_Y, COMP_CB, COMP_CR} comp_e` (also the FSM state type);
  - `typedef struct packed {fixedLength_t word; logic last;} arb_entry_t`.
- Sub-module `arb_fifo`: synchronous FIFO of `arb_entry_t`, `DEPTH` deep, with a flush input. Instantiated three times.

## Test plan
- 4:4:4, each component sends one 3-word block (Y: A0..A2, Cb: B0..B2, Cr: C0..C2), `out_ready = 1`:
  - output order is A0 A1 A2 B0 B1 B2 C0 C1 C2 on 9 consecutive cycles;
  - `out_mcu_last` is set only on C2;
  - `mcu_count = 1`.
- `Y_BLOCKS = 4`, Cr data arrives first:
  - no Cr word is output until 4 Y blocks complete;
  - the Cr FIFO fills to `DEPTH`, then `in_ready[2] = 0`.
- `out_ready` toggled randomly:
  - `out_word` is stable during every stall;
  - no word is lost or duplicated over 100 MCUs;
  - `mcu_count = 100`.
- `frame_start` asserted mid Cb block, with a push in the same cycle:
  - next cycle all FIFOs are empty, state `GNT_Y`, `mcu_count = 0`;
  - the pushed word is discarded.
- Async reset asserted mid-stream: all outputs take their reset values immediately, without waiting for a `clk` edge.
- With `JPEG_ARB_STALL_CNT_EN`: holding Y full while `in_valid[0] = 1` for 20 cycles gives `stall_cnt[0] = 20`; the other counters stay at 0.
